// File: rtl/joystick_pkg.sv
// Joystick bit map shared by the mainboard, the keyboard joystick emulation and this conditioner.
// Index 0 is fire; vectors are active-high once past the input synchronizers.
package joystick_pkg;

  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;
  localparam int JOY_WIDTH = 5;

  typedef logic [JOY_WIDTH-1:0] joy_vec_t;

  // Opposing directions cancel to neutral; fire is never touched.
  function automatic joy_vec_t socd_clean(input joy_vec_t v, input logic neutral);
    joy_vec_t r;
    r = v;
    if (neutral && v[JOY_LEFT] && v[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b0;
      r[JOY_RIGHT] = 1'b0;
    end
    if (neutral && v[JOY_DOWN] && v[JOY_UP]) begin
      r[JOY_DOWN] = 1'b0;
      r[JOY_UP]   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/joystick_debounce_bit.sv
// One joystick line: 2-flop synchronizer on the active-low pin, then a counter debounce.
// The line must disagree with the accepted state for 2**DEBOUNCE_BITS samples in a row.
module joystick_debounce_bit #(
  parameter int DEBOUNCE_BITS = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic stable
);

  logic                     r_s1;
  logic                     r_s2;
  logic                     r_stable;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     w_active;

  assign w_active = ~r_s2;
  assign stable   = r_stable;

  // Sync flops preset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= raw_n;
      r_s2 <= r_s1;
      if (w_active == r_stable) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_stable <= w_active;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joystick_conditioner.sv
// Two-port joystick conditioner: debounce, SOCD cleanup, port swap, registered outputs, change strobe.
// Define JOYSTICK_AUTOFIRE_EN to add the per-port autofire input and the shared autofire divider.
module joystick_conditioner
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 18,
  parameter int AUTOFIRE_BITS = 22,
  parameter int SOCD_NEUTRAL  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [JOY_WIDTH-1:0] joy1_raw_n,
  input  logic [JOY_WIDTH-1:0] joy2_raw_n,
  input  logic                 swap_ports,
`ifdef JOYSTICK_AUTOFIRE_EN
  input  logic [1:0]           autofire,
`endif
  output logic [JOY_WIDTH-1:0] joy1,
  output logic [JOY_WIDTH-1:0] joy2,
  output logic                 joy_event
);

  joy_vec_t w_deb1, w_deb2;
  joy_vec_t w_clean1, w_clean2;
  joy_vec_t w_gated1, w_gated2;

  for (genvar g = 0; g < JOY_WIDTH; g++) begin : g_bit
    joystick_debounce_bit #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_port1 (
      .clk    (clk),
      .reset  (reset),
      .raw_n  (joy1_raw_n[g]),
      .stable (w_deb1[g])
    );
    joystick_debounce_bit #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_port2 (
      .clk    (clk),
      .reset  (reset),
      .raw_n  (joy2_raw_n[g]),
      .stable (w_deb2[g])
    );
  end

  assign w_clean1 = socd_clean(w_deb1, SOCD_NEUTRAL != 0);
  assign w_clean2 = socd_clean(w_deb2, SOCD_NEUTRAL != 0);

`ifdef JOYSTICK_AUTOFIRE_EN
  logic [AUTOFIRE_BITS-1:0] r_div;
  logic [1:0]               r_phase;
  logic [1:0]               w_fire;
  logic                     w_tick;

  assign w_fire = {w_clean2[JOY_FIRE], w_clean1[JOY_FIRE]};
  assign w_tick = &r_div;

  // Phase idles at 1 so a fresh press always starts with fire asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_phase <= 2'b11;
    end else begin
      r_div <= r_div + 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (!(autofire[p] && w_fire[p])) begin
          r_phase[p] <= 1'b1;
        end else if (w_tick) begin
          r_phase[p] <= ~r_phase[p];
        end
      end
    end
  end

  always_comb begin
    w_gated1 = w_clean1;
    w_gated2 = w_clean2;
    w_gated1[JOY_FIRE] = w_clean1[JOY_FIRE] & (~autofire[0] | r_phase[0]);
    w_gated2[JOY_FIRE] = w_clean2[JOY_FIRE] & (~autofire[1] | r_phase[1]);
  end
`else
  assign w_gated1 = w_clean1;
  assign w_gated2 = w_clean2;

  if (AUTOFIRE_BITS < 1) begin : g_autofire_bits_unused
  end
`endif

  logic [JOY_WIDTH-1:0]   r_joy1, r_joy2;
  logic [2*JOY_WIDTH-1:0] r_prev;
  logic                   r_event;

  // The event compares the registered pair against its previous value, so it trails the output by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_joy1  <= '0;
      r_joy2  <= '0;
      r_prev  <= '0;
      r_event <= 1'b0;
    end else begin
      r_joy1  <= swap_ports ? w_gated2 : w_gated1;
      r_joy2  <= swap_ports ? w_gated1 : w_gated2;
      r_prev  <= {r_joy1, r_joy2};
      r_event <= ({r_joy1, r_joy2} != r_prev);
    end
  end

  assign joy1      = r_joy1;
  assign joy2      = r_joy2;
  assign joy_event = r_event;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with a sliding-window reference model checked every cycle.
// Vectors are indexed by the joystick_pkg bit numbers (index 0 = fire).
module tb_joystick_conditioner;
  import joystick_pkg::*;

  localparam int DB    = 4;
  localparam int AB    = 3;
  localparam int DEPTH = 1 << DB;
  localparam int AP    = 1 << AB;

  localparam logic [4:0] B_FIRE  = 5'b00001;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] joy1_raw_n, joy2_raw_n;
  logic       swap_ports;
  logic [1:0] af;
  logic [4:0] joy1, joy2;
  logic       joy_event;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  joystick_conditioner #(.DEBOUNCE_BITS(DB), .AUTOFIRE_BITS(AB), .SOCD_NEUTRAL(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy1_raw_n (joy1_raw_n),
    .joy2_raw_n (joy2_raw_n),
    .swap_ports (swap_ports),
`ifdef JOYSTICK_AUTOFIRE_EN
    .autofire   (af),
`endif
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_event  (joy_event)
  );

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is accepted once the last 2**DB synchronized samples all disagree with it.
  logic [4:0]       m_s1[2], m_s2[2], m_stb[2];
  logic [DEPTH-1:0] m_win[2][5];
  logic [4:0]       m_j1, m_j2;
  logic [9:0]       m_prev;
  logic             m_event;
  logic [1:0]       m_ph;
  int               m_div;
  bit               m_valid = 1'b0;

  function automatic logic [4:0] m_socd(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (v[JOY_LEFT] && v[JOY_RIGHT]) begin r[JOY_LEFT] = 1'b0; r[JOY_RIGHT] = 1'b0; end
    if (v[JOY_DOWN] && v[JOY_UP])    begin r[JOY_DOWN] = 1'b0; r[JOY_UP]    = 1'b0; end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [4:0] raw[2];
    logic [4:0] c[2];
    logic [4:0] act;
    m_valid = 1'b1;
    raw[0] = joy1_raw_n;
    raw[1] = joy2_raw_n;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_s1[p] = '1; m_s2[p] = '1; m_stb[p] = '0;
        for (int b = 0; b < 5; b++) m_win[p][b] = '0;
      end
      m_j1 = '0; m_j2 = '0; m_prev = '0; m_event = 1'b0; m_ph = 2'b11; m_div = 0;
    end else begin
      m_event = ({m_j1, m_j2} != m_prev);
      m_prev  = {m_j1, m_j2};
      for (int p = 0; p < 2; p++) begin
        c[p] = m_socd(m_stb[p]);
`ifdef JOYSTICK_AUTOFIRE_EN
        if (af[p]) c[p][JOY_FIRE] = c[p][JOY_FIRE] & m_ph[p];
`endif
      end
      m_j1 = swap_ports ? c[1] : c[0];
      m_j2 = swap_ports ? c[0] : c[1];
`ifdef JOYSTICK_AUTOFIRE_EN
      for (int p = 0; p < 2; p++) begin
        if (!(af[p] && m_stb[p][JOY_FIRE])) m_ph[p] = 1'b1;
        else if ((m_div % AP) == AP - 1) m_ph[p] = ~m_ph[p];
      end
`endif
      m_div++;
      for (int p = 0; p < 2; p++) begin
        act = ~m_s2[p];
        for (int b = 0; b < 5; b++) begin
          m_win[p][b] = {m_win[p][b][DEPTH-2:0], act[b]};
          if (m_win[p][b] == {DEPTH{~m_stb[p][b]}}) m_stb[p][b] = ~m_stb[p][b];
        end
        m_s2[p] = m_s1[p];
        m_s1[p] = raw[p];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_joy1", {5'b0, joy1}, {5'b0, m_j1});
      chk("model_joy2", {5'b0, joy2}, {5'b0, m_j2});
      chk("model_event", {9'b0, joy_event}, {9'b0, m_event});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    int ntog, last_t, gaps_ok;
    logic prev_f;
    reset = 1'b1; joy1_raw_n = '1; joy2_raw_n = '1; swap_ports = 1'b0; af = 2'b00;

    // Reset behaviour, including pins held low throughout reset
    cyc(3);
    chk("rst_joy1", {5'b0, joy1}, 10'd0);
    chk("rst_joy2", {5'b0, joy2}, 10'd0);
    chk("rst_event", {9'b0, joy_event}, 10'd0);
    joy1_raw_n = '0; joy2_raw_n = '0;
    cyc(30);
    chk("rst_hold_joy1", {5'b0, joy1}, 10'd0);
    chk("rst_hold_joy2", {5'b0, joy2}, 10'd0);
    joy1_raw_n = '1; joy2_raw_n = '1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("release_event", {9'b0, joy_event}, 10'd0);
    cyc(5);

    // Up press: output moves on the 19th edge, event one edge later
    joy1_raw_n[JOY_UP] = 1'b0;
    cyc(18);
    chk("up_edge18", {5'b0, joy1}, 10'd0);
    cyc(1);
    chk("up_edge19", {5'b0, joy1}, {5'b0, B_UP});
    chk("up_ev_early", {9'b0, joy_event}, 10'd0);
    cyc(1);
    chk("up_ev_pulse", {9'b0, joy_event}, 10'd1);
    cyc(1);
    chk("up_ev_single", {9'b0, joy_event}, 10'd0);
    joy1_raw_n[JOY_UP] = 1'b1;
    cyc(25);
    chk("up_release", {5'b0, joy1}, 10'd0);

    // Glitch rejection: 10 and 15 low cycles dropped, exactly 16 accepted
    seen = 1'b0;
    joy2_raw_n[JOY_FIRE] = 1'b0; cyc(10); joy2_raw_n[JOY_FIRE] = 1'b1;
    repeat (30) begin @(negedge clk); seen |= joy_event | (|joy2); end
    chk("glitch10_seen", {9'b0, seen}, 10'd0);
    seen = 1'b0;
    joy2_raw_n[JOY_FIRE] = 1'b0; cyc(15); joy2_raw_n[JOY_FIRE] = 1'b1;
    repeat (30) begin @(negedge clk); seen |= joy_event | (|joy2); end
    chk("glitch15_seen", {9'b0, seen}, 10'd0);
    seen = 1'b0;
    joy2_raw_n[JOY_FIRE] = 1'b0; cyc(16); joy2_raw_n[JOY_FIRE] = 1'b1;
    repeat (30) begin @(negedge clk); seen |= joy2[JOY_FIRE]; end
    chk("pulse16_seen", {9'b0, seen}, 10'd1);
    cyc(20);

    // SOCD: left+right cancel, releasing right leaves left
    joy1_raw_n[JOY_LEFT] = 1'b0; joy1_raw_n[JOY_RIGHT] = 1'b0;
    cyc(25);
    chk("socd_lr", {5'b0, joy1}, 10'd0);
    joy1_raw_n[JOY_RIGHT] = 1'b1;
    cyc(25);
    chk("socd_left", {5'b0, joy1}, {5'b0, B_LEFT});
    joy1_raw_n = '1;
    cyc(25);

    // Swap with only port 1 fire held
    joy1_raw_n[JOY_FIRE] = 1'b0;
    cyc(25);
    chk("pre_swap", {joy1, joy2}, {B_FIRE, 5'b0});
    swap_ports = 1'b1;
    cyc(1);
    chk("swap_out", {joy1, joy2}, {5'b0, B_FIRE});
    cyc(1);
    chk("swap_ev", {9'b0, joy_event}, 10'd1);
    cyc(1);
    chk("swap_ev_single", {9'b0, joy_event}, 10'd0);
    swap_ports = 1'b0;
    joy1_raw_n = '1;
    cyc(25);
    chk("idle", {joy1, joy2}, 10'd0);
    chk("unused_right", {5'b0, joy2 & B_RIGHT}, 10'd0);

`ifdef JOYSTICK_AUTOFIRE_EN
    // Autofire on port 1: starts high, toggles every AP cycles, released and reset to 0
    af = 2'b01;
    joy1_raw_n[JOY_FIRE] = 1'b0;
    cyc(19);
    chk("af_start", {5'b0, joy1}, {5'b0, B_FIRE});
    ntog = 0; last_t = -1; gaps_ok = 1; prev_f = joy1[JOY_FIRE];
    for (int t = 0; t < 5 * AP; t++) begin
      @(negedge clk);
      if (joy1[JOY_FIRE] != prev_f) begin
        if (last_t >= 0 && (t - last_t) != AP) gaps_ok = 0;
        last_t = t; ntog++;
      end
      prev_f = joy1[JOY_FIRE];
    end
    chk("af_gaps", gaps_ok[9:0], 10'd1);
    chk("af_toggles", {9'b0, ntog >= 4}, 10'd1);
    joy1_raw_n[JOY_FIRE] = 1'b1;
    cyc(25);
    chk("af_release", {5'b0, joy1}, 10'd0);
    joy1_raw_n[JOY_FIRE] = 1'b0;
    cyc(30);
    reset = 1'b1;
    cyc(1);
    chk("af_reset", {5'b0, joy1}, 10'd0);
    joy1_raw_n = '1;
    cyc(2);
    reset = 1'b0;
    af = 2'b00;
    cyc(5);
`endif

    // Reset in the middle of a debounce discards the partial count
    joy2_raw_n[JOY_LEFT] = 1'b0;
    cyc(12);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    chk("mid_reset_partial", {5'b0, joy2}, 10'd0);
    cyc(15);
    chk("mid_reset_after", {5'b0, joy2}, {5'b0, B_LEFT});
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
